block_read_collector: RTL

Consumer side of the multiplier's block-read port. On a `start` pulse it issues a one-cycle `EN_blockRead` request, captures the 64-word `VALID_memVal`/`memVal_data` burst into a small FIFO and re-emits the words on a valid/ready stream tagged with index and last flag. It also keeps a running sum and flags overflow and timeout errors. It sits between the multiplier's result memory and any downstream consumer (checker, host interface).

---
 rtl/block_read_collector_if.sv | 37 +++
 rtl/block_read_collector.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/block_read_collector_if.sv
// Bundles the multiplier block-read port and the downstream valid/ready stream.
// Master is the collector; slave is the multiplier plus downstream consumer.
interface block_read_collector_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 6
) ();
  logic              EN_blockRead;
  logic              VALID_memVal;
  logic [WIDTH-1:0]  memVal_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;

  modport master (
    output EN_blockRead,
    input  VALID_memVal,
    input  memVal_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_idx,
    output out_last
  );

  modport slave (
    input  EN_blockRead,
    output VALID_memVal,
    output memVal_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_idx,
    input  out_last
  );
endinterface

// File: rtl/block_read_collector.sv
// Requests one block read, captures the word burst into a small FIFO and re-emits it as an
// indexed stream, keeping a running sum plus sticky overflow/timeout flags.
module block_read_collector #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  block_read_collector_if.master    bus,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH+ADDR_W-1:0]   sum,
  output logic                      err_overflow,
  output logic                      err_timeout
);

  localparam int unsigned SumW  = WIDTH + ADDR_W;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StRecv, StDrain, StDone} stateT;

  stateT             state;
  logic              enBlockRead;
  logic [ADDR_W-1:0] wordCnt;
  logic [IdleW-1:0]  idleCnt;

  logic [WIDTH-1:0]  dataMem [FIFO_DEPTH];
  logic [ADDR_W-1:0] idxMem  [FIFO_DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [PtrW-1:0]   headPtr;
  logic [CntW-1:0]   fifoCnt;

  logic fifoEmpty;
  logic fifoFull;
  logic capture;
  logic pop;
  logic push;
  logic overflow;

  assign fifoEmpty = (fifoCnt == '0);
  assign fifoFull  = (fifoCnt == CntW'(FIFO_DEPTH));
  assign capture   = bus.VALID_memVal && ((state == StWait) || (state == StRecv));
  assign pop       = !fifoEmpty && bus.out_ready;
  // A full FIFO still takes the word if the head leaves on the same edge.
  assign push      = capture && (!fifoFull || pop);
  assign overflow  = capture && fifoFull && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      enBlockRead  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sum          <= '0;
      wordCnt      <= '0;
      idleCnt      <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      enBlockRead <= 1'b0;
      done        <= 1'b0;
      // Sum and count track every captured word, even ones the FIFO drops.
      if (capture) begin
        sum     <= sum + SumW'(bus.memVal_data);
        wordCnt <= wordCnt + ADDR_W'(1);
        idleCnt <= '0;
        if (overflow) err_overflow <= 1'b1;
      end
      case (state)
        StIdle: begin
          if (start) begin
            state        <= StReq;
            enBlockRead  <= 1'b1;
            busy         <= 1'b1;
            sum          <= '0;
            wordCnt      <= '0;
            idleCnt      <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
          end
        end
        StReq: state <= StWait;
        StWait, StRecv: begin
          if (capture) begin
            if (state == StWait) begin
              state <= StRecv;
            end else if (wordCnt == ADDR_W'(DEPTH - 1)) begin
              state <= StDrain;
            end
          end else if (idleCnt == IdleW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= StDrain;
          end else begin
            idleCnt <= idleCnt + IdleW'(1);
          end
        end
        StDrain: begin
          if (fifoEmpty) begin
            state <= StDone;
            done  <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        dataMem[i] <= '0;
        idxMem[i]  <= '0;
      end
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (push) begin
        dataMem[wrPtr] <= bus.memVal_data;
        idxMem[wrPtr]  <= wordCnt;
        wrPtr          <= wrPtr + PtrW'(1);
      end
      if (pop) rdPtr <= rdPtr + PtrW'(1);
      case ({push, pop})
        2'b10:   fifoCnt <= fifoCnt + CntW'(1);
        2'b01:   fifoCnt <= fifoCnt - CntW'(1);
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // When empty, point at the slot just popped so the head holds its last value.
  assign headPtr = fifoEmpty ? (rdPtr - PtrW'(1)) : rdPtr;

  assign bus.EN_blockRead = enBlockRead;
  assign bus.out_valid    = !fifoEmpty;
  assign bus.out_data     = dataMem[headPtr];
  assign bus.out_idx      = idxMem[headPtr];
  assign bus.out_last     = !fifoEmpty && (idxMem[headPtr] == ADDR_W'(DEPTH - 1));

endmodule
